// File: rtl/spi_arb_pkg.sv
// Shared constants and FSM encoding for the SPI transaction arbiter.
package spi_arb_pkg;

    localparam int SPI_W = 8;
    localparam logic [SPI_W-1:0] ERR_BYTE = 8'h00;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_ISSUE     = 3'd1,
        ST_WAIT_BUSY = 3'd2,
        ST_WAIT_DONE = 3'd3,
        ST_RESP      = 3'd4,
        ST_GAP       = 3'd5
    } arb_state_t;

endpackage

// File: rtl/spi_txn_arbiter_rr.sv
// Combinational round-robin pick: first set request at or above the pointer,
// wrapping by compare so non-power-of-two requester counts work.
module rr_arbiter #(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]         i_req,
    input  logic [$clog2(NUM_REQ)-1:0] i_ptr,
    output logic [NUM_REQ-1:0]         o_grant,
    output logic [$clog2(NUM_REQ)-1:0] o_idx,
    output logic                       o_valid
);
    localparam int IW = $clog2(NUM_REQ);

    int w_j;

    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        o_valid = 1'b0;
        w_j     = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_j = int'(i_ptr) + k;
            if (w_j >= NUM_REQ) w_j = w_j - NUM_REQ;
            if (!o_valid && i_req[w_j]) begin
                o_valid      = 1'b1;
                o_grant[w_j] = 1'b1;
                o_idx        = w_j[IW-1:0];
            end
        end
    end

endmodule

// File: rtl/spi_txn_arbiter.sv
// Shares one SPI master engine among NUM_REQ requesters: round-robin pick,
// start pulse, busy tracking with timeout, done/response, then a CS-high gap.
module spi_txn_arbiter
    import spi_arb_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int GAP_CYCLES = 4,
    parameter int TIMEOUT    = 15
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [NUM_REQ*SPI_W-1:0] req_data,
    output logic [NUM_REQ-1:0]       grant,
    output logic [NUM_REQ-1:0]       done,
    output logic [SPI_W-1:0]         rsp_data,
    output logic                     err,
    output logic                     m_start,
    output logic [SPI_W-1:0]         m_data_in,
    input  logic                     m_busy,
    input  logic [SPI_W-1:0]         m_data_out
);
    localparam int IW = $clog2(NUM_REQ);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int GW = $clog2(GAP_CYCLES + 1);

    arb_state_t         r_state, w_next;
    logic [IW-1:0]      r_ptr, r_idx;
    logic [NUM_REQ-1:0] r_grant;
    logic [SPI_W-1:0]   r_data_in, r_rsp;
    logic [TW-1:0]      r_tmo;
    logic [GW-1:0]      r_gap;
    logic               r_err_flag;

    logic [NUM_REQ-1:0] w_arb_grant;
    logic [IW-1:0]      w_arb_idx;
    logic               w_arb_valid;
    logic               w_tmo_hit, w_gap_end;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
        .i_req   (req),
        .i_ptr   (r_ptr),
        .o_grant (w_arb_grant),
        .o_idx   (w_arb_idx),
        .o_valid (w_arb_valid)
    );

    assign w_tmo_hit = (r_tmo == TW'(TIMEOUT - 1));
    assign w_gap_end = (r_gap == GW'(GAP_CYCLES - 1));

    always_comb begin
        w_next = r_state;
        case (r_state)
            // foreign engine activity blocks arbitration entirely
            ST_IDLE:      if (w_arb_valid && !m_busy) w_next = ST_ISSUE;
            ST_ISSUE:     w_next = ST_WAIT_BUSY;
            ST_WAIT_BUSY: if (m_busy) w_next = ST_WAIT_DONE;
                          else if (w_tmo_hit) w_next = ST_RESP;
            ST_WAIT_DONE: if (!m_busy) w_next = ST_RESP;
            ST_RESP:      w_next = ST_GAP;
            ST_GAP:       if (w_gap_end) w_next = ST_IDLE;
            default:      w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_ptr      <= '0;
            r_idx      <= '0;
            r_grant    <= '0;
            r_data_in  <= '0;
            r_rsp      <= '0;
            r_tmo      <= '0;
            r_gap      <= '0;
            r_err_flag <= 1'b0;
        end else begin
            r_state <= w_next;
            case (r_state)
                ST_IDLE: if (w_next == ST_ISSUE) begin
                    r_grant   <= w_arb_grant;
                    r_idx     <= w_arb_idx;
                    r_data_in <= req_data[w_arb_idx*SPI_W +: SPI_W];
                end
                ST_WAIT_BUSY: begin
                    if (m_busy) begin
                        r_tmo <= '0;
                    end else if (w_tmo_hit) begin
                        r_tmo      <= '0;
                        r_err_flag <= 1'b1;
                        r_rsp      <= ERR_BYTE;
                    end else begin
                        r_tmo <= r_tmo + 1'b1;
                    end
                end
                ST_WAIT_DONE: if (!m_busy) r_rsp <= m_data_out;
                ST_RESP: begin
                    r_grant    <= '0;
                    r_err_flag <= 1'b0;
                    r_gap      <= '0;
                    r_ptr      <= (r_idx == IW'(NUM_REQ - 1)) ? '0 : r_idx + 1'b1;
                end
                ST_GAP: r_gap <= w_gap_end ? '0 : r_gap + 1'b1;
                default: ;
            endcase
        end
    end

    assign grant     = r_grant;
    assign done      = (r_state == ST_RESP) ? r_grant : '0;
    assign err       = (r_state == ST_RESP) && r_err_flag;
    assign m_start   = (r_state == ST_ISSUE);
    assign m_data_in = r_data_in;
    assign rsp_data  = r_rsp;

endmodule

// File: tb/tb_spi_txn_arbiter.sv
// Directed plus randomized bench for spi_txn_arbiter with an SPI engine model
// and a round-robin reference model.
module tb_spi_txn_arbiter;
    localparam int N    = 4;
    localparam int GAP  = 4;
    localparam int TOUT = 15;

    logic           clk, rst;
    logic [N-1:0]   req;
    logic [N*8-1:0] req_data;
    logic [N-1:0]   grant, done;
    logic [7:0]     rsp_data, m_data_in, m_data_out;
    logic           err, m_start, m_busy;
    logic           eng_busy, foreign_busy;

    spi_txn_arbiter #(.NUM_REQ(N), .GAP_CYCLES(GAP), .TIMEOUT(TOUT)) dut (
        .clk(clk), .rst(rst), .req(req), .req_data(req_data),
        .grant(grant), .done(done), .rsp_data(rsp_data), .err(err),
        .m_start(m_start), .m_data_in(m_data_in),
        .m_busy(m_busy), .m_data_out(m_data_out)
    );

    assign m_busy = eng_busy | foreign_busy;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_start = 0, last_start_cyc = 0, n_done = 0;
    always @(negedge clk) begin
        if (m_start === 1'b1) begin
            n_start        <= n_start + 1;
            last_start_cyc <= cyc;
        end
        if (|done) n_done <= n_done + 1;
    end

    // engine model: optional delay to busy, busy for eng_len cycles, returns tx ^ eng_xor
    int         eng_dly = 0, eng_len = 2, eng_fall_cyc = 0;
    logic [7:0] eng_xor = 8'h99, eng_s_byte = 8'h00, eng_f_byte = 8'h00;
    logic       eng_never = 1'b0;
    initial begin
        eng_busy   = 1'b0;
        m_data_out = 8'h00;
        forever begin
            @(posedge clk);
            if (m_start === 1'b1 && !eng_never) begin
                #1;
                eng_s_byte = m_data_in;
                repeat (eng_dly) @(posedge clk);
                if (eng_dly > 0) #1;
                eng_busy = 1'b1;
                repeat (eng_len) @(posedge clk);
                #1;
                eng_f_byte   = m_data_in;
                eng_busy     = 1'b0;
                m_data_out   = eng_s_byte ^ eng_xor;
                eng_fall_cyc = cyc;
            end
        end
    end

    int         n_checks = 0, n_err = 0;
    int         model_ptr = 0, prev_starts = 0, last_done_cyc = 0;
    logic [7:0] bytes [N];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp_v);
        end
    endtask

    function automatic int rr_pick(input logic [N-1:0] m, input int p);
        for (int k = 0; k < N; k++)
            if (m[(p + k) % N]) return (p + k) % N;
        return -1;
    endfunction

    task automatic raise(input int i, input logic [7:0] b);
        req[i]            = 1'b1;
        req_data[8*i +: 8] = b;
        bytes[i]          = b;
    endtask

    task automatic wait_busy(input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (m_busy === 1'b1) break;
        end
        chk("busy_seen", 32'(m_busy), 32'd1);
    endtask

    task automatic wait_grant(input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (|grant) break;
        end
        chk("grant_seen", 32'(|grant), 32'd1);
    endtask

    task automatic wait_done(input int budget, output logic [N-1:0] d, output logic [7:0] r,
                             output logic e, output int dc);
        d = '0; r = 8'h00; e = 1'b0; dc = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (|done) begin
                d = done; r = rsp_data; e = err; dc = cyc;
                break;
            end
        end
        chk("done_seen", 32'(dc >= 0), 32'd1);
    endtask

    task automatic check_txn(input int w, input logic [7:0] b, input logic to, input logic chk_gap);
        logic [N-1:0] d;
        logic [7:0]   r;
        logic         e;
        int           dc, pdc;
        pdc = last_done_cyc;
        wait_done(300, d, r, e, dc);
        req = req & ~d;
        chk("done_owner", 32'(d), 32'd1 << w);
        chk("rsp_data", 32'(r), to ? 32'd0 : 32'(b ^ eng_xor));
        chk("err", 32'(e), 32'(to));
        chk("start_count", 32'(n_start - prev_starts), 32'd1);
        prev_starts = n_start;
        if (to) begin
            chk("timeout_lat", 32'(dc - last_start_cyc), 32'(TOUT + 1));
        end else begin
            chk("tx_byte_start", 32'(eng_s_byte), 32'(b));
            chk("tx_byte_end", 32'(eng_f_byte), 32'(b));
            chk("done_lat", 32'(dc - eng_fall_cyc), 32'd1);
        end
        if (chk_gap) chk("gap", 32'(last_start_cyc - pdc), 32'(GAP + 2));
        last_done_cyc = dc;
        model_ptr     = (w + 1) % N;
    endtask

    initial begin
        int w, rc, snap;
        rst = 1'b1; req = '0; req_data = '0; foreign_busy = 1'b0;
        for (int i = 0; i < N; i++) bytes[i] = 8'h00;
        repeat (3) @(negedge clk);
        chk("rst_grant", 32'(grant), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_rsp", 32'(rsp_data), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_start", 32'(m_start), 32'd0);
        chk("rst_mdi", 32'(m_data_in), 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // single request, then back-to-back from the same requester
        @(posedge clk); #1;
        rc = cyc;
        raise(0, 8'hA5);
        check_txn(rr_pick(req, model_ptr), 8'hA5, 1'b0, 1'b0);
        chk("start_lat", 32'(last_start_cyc - rc), 32'd1);
        raise(0, 8'h11);
        check_txn(rr_pick(req, model_ptr), 8'h11, 1'b0, 1'b1);

        // all four at once after reset
        @(negedge clk); rst = 1'b1;
        repeat (2) @(negedge clk); rst = 1'b0;
        model_ptr = 0; prev_starts = n_start;
        eng_len = 3; eng_xor = 8'h3C;
        for (int i = 0; i < N; i++) raise(i, 8'(8'h10 + 8'h11 * i));
        for (int i = 0; i < N; i++) begin
            w = rr_pick(req, model_ptr);
            chk("rr_order_model", 32'(w), 32'(i));
            check_txn(w, bytes[w], 1'b0, i > 0);
        end

        // fairness: req0 persistent, req2 once
        raise(0, 8'h55);
        check_txn(rr_pick(req, model_ptr), 8'h55, 1'b0, 1'b0);
        raise(0, 8'h56); raise(2, 8'h77);
        check_txn(rr_pick(req, model_ptr), 8'h77, 1'b0, 1'b1);
        check_txn(rr_pick(req, model_ptr), 8'h56, 1'b0, 1'b1);

        // engine never goes busy
        eng_never = 1'b1;
        raise(3, 8'h99);
        check_txn(rr_pick(req, model_ptr), 8'h99, 1'b1, 1'b0);
        eng_never = 1'b0;

        // foreign busy blocks arbitration
        foreign_busy = 1'b1;
        raise(1, 8'h42);
        repeat (12) @(negedge clk);
        chk("foreign_no_start", 32'(n_start - prev_starts), 32'd0);
        chk("foreign_no_grant", 32'(grant), 32'd0);
        foreign_busy = 1'b0;
        check_txn(rr_pick(req, model_ptr), 8'h42, 1'b0, 1'b0);

        // req dropped mid-transfer is not a cancel
        eng_len = 6; eng_xor = 8'h99;
        raise(1, 8'h3A);
        w = rr_pick(req, model_ptr);
        wait_busy(40);
        repeat (2) @(negedge clk);
        req[1] = 1'b0;
        check_txn(w, 8'h3A, 1'b0, 1'b0);

        // reset in WAIT_DONE
        eng_len = 10;
        raise(1, 8'h66);
        wait_busy(40);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("mid_rst_grant", 32'(grant), 32'd0);
        chk("mid_rst_done", 32'(done), 32'd0);
        chk("mid_rst_start", 32'(m_start), 32'd0);
        chk("mid_rst_rsp", 32'(rsp_data), 32'd0);
        chk("mid_rst_mdi", 32'(m_data_in), 32'd0);
        snap = n_done;
        req = '0;
        raise(0, 8'h01); raise(2, 8'h02);
        repeat (15) @(negedge clk);
        #1;
        chk("no_done_in_rst", 32'(n_done - snap), 32'd0);
        @(negedge clk); rst = 1'b0;
        model_ptr = 0; prev_starts = n_start; eng_len = 2;
        w = rr_pick(req, model_ptr);
        chk("post_rst_winner_model", 32'(w), 32'd0);
        check_txn(w, bytes[w], 1'b0, 1'b0);
        check_txn(rr_pick(req, model_ptr), 8'h02, 1'b0, 1'b1);

        // req_data changes right after grant
        raise(3, 8'h5A);
        wait_grant(40);
        req_data[31:24] = 8'hFF;
        check_txn(rr_pick(req, model_ptr), 8'h5A, 1'b0, 1'b0);

        // randomized traffic against the round-robin model
        eng_dly = int'($urandom_range(0, 3)); eng_len = int'($urandom_range(1, 4));
        eng_xor = 8'($urandom); eng_never = ($urandom_range(0, 5) == 0);
        for (int it = 0; it < 40; it++) begin
            if (req == '0) raise(int'($urandom_range(0, N - 1)), 8'($urandom));
            w = rr_pick(req, model_ptr);
            check_txn(w, bytes[w], eng_never, it > 0);
            for (int i = 0; i < N; i++)
                if (!req[i] && $urandom_range(0, 2) == 0) raise(i, 8'($urandom));
            eng_dly = int'($urandom_range(0, 3)); eng_len = int'($urandom_range(1, 4));
            eng_xor = 8'($urandom); eng_never = ($urandom_range(0, 5) == 0);
        end

        repeat (5) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
